// File: rtl/conv_layer.sv
// conv_layer: streaming 3x3 "valid" convolution over a 28x28 8-bit image.
//
// The engine walks the 26x26 output positions in raster order. For each
// output pixel it reads the nine window pixels from an external synchronous
// image RAM (1-cycle read latency). It multiply-accumulates them against one
// of four fixed kernels. It then emits the ReLU-clamped, saturated 8-bit
// result. Each output pixel takes 11 cycles: 9 FETCH, 1 DRAIN, 1 OUT.
//
// Ports:
//   clk           : clock, rising edge active
//   rst           : asynchronous active-high reset
//   start         : run start pulse, sampled only while idle
//   filter_select : kernel index 0..3, latched when start is accepted
//   img_addr      : image RAM read address (row*28+col), combinational
//   img_data      : image RAM read data for the previous cycle's address
//   data_out      : output feature pixel, holds between strobes
//   valid_out     : one-cycle strobe qualifying data_out
//   done          : one-cycle pulse in the cycle after the last strobe
module conv_layer (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [1:0] filter_select,
    output logic [9:0] img_addr,
    input  logic [7:0] img_data,
    output logic [7:0] data_out,
    output logic       valid_out,
    output logic       done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DRAIN,
        S_OUT,
        S_DONE
    } state_t;

    state_t state, state_next;

    logic [4:0]         row;
    logic [4:0]         col;
    logic [3:0]         k;
    logic [1:0]         filt;
    logic signed [12:0] acc;

    logic [1:0]         k_row;
    logic [1:0]         k_col;
    logic [4:0]         win_row;
    logic [4:0]         win_col;
    logic [3:0]         w_idx;
    logic signed [3:0]  w_cur;
    logic signed [12:0] pix_ext;
    logic signed [12:0] w_ext;
    logic signed [12:0] prod;
    logic signed [12:0] acc_sum;
    logic               last_pixel;

    // Kernel coefficients, row-major; zero entries fall to the default.
    function automatic logic signed [3:0] weight(input logic [1:0] f,
                                                 input logic [3:0] idx);
        logic signed [3:0] w;
        w = 4'sd0;
        case ({f, idx})
            {2'd0, 4'd0}: w = -4'sd1;
            {2'd0, 4'd2}: w =  4'sd1;
            {2'd0, 4'd3}: w = -4'sd2;
            {2'd0, 4'd5}: w =  4'sd2;
            {2'd0, 4'd6}: w = -4'sd1;
            {2'd0, 4'd8}: w =  4'sd1;
            {2'd1, 4'd0}: w = -4'sd1;
            {2'd1, 4'd1}: w = -4'sd2;
            {2'd1, 4'd2}: w = -4'sd1;
            {2'd1, 4'd6}: w =  4'sd1;
            {2'd1, 4'd7}: w =  4'sd2;
            {2'd1, 4'd8}: w =  4'sd1;
            {2'd2, 4'd1}: w = -4'sd1;
            {2'd2, 4'd3}: w = -4'sd1;
            {2'd2, 4'd4}: w =  4'sd4;
            {2'd2, 4'd5}: w = -4'sd1;
            {2'd2, 4'd7}: w = -4'sd1;
            {2'd3, 4'd0}: w =  4'sd2;
            {2'd3, 4'd1}: w =  4'sd1;
            {2'd3, 4'd3}: w =  4'sd1;
            {2'd3, 4'd5}: w = -4'sd1;
            {2'd3, 4'd7}: w = -4'sd1;
            {2'd3, 4'd8}: w = -4'sd2;
            default:      w =  4'sd0;
        endcase
        return w;
    endfunction

    // ReLU followed by saturation to the 8-bit pixel range.
    function automatic logic [7:0] relu_sat(input logic signed [12:0] a);
        logic [7:0] r;
        if (a < 13'sd0)
            r = 8'd0;
        else if (a > 13'sd255)
            r = 8'd255;
        else
            r = a[7:0];
        return r;
    endfunction

    // Window offset of tap k within the 3x3 neighbourhood.
    always_comb begin
        k_row = 2'd0;
        k_col = 2'd0;
        case (k)
            4'd1: begin k_row = 2'd0; k_col = 2'd1; end
            4'd2: begin k_row = 2'd0; k_col = 2'd2; end
            4'd3: begin k_row = 2'd1; k_col = 2'd0; end
            4'd4: begin k_row = 2'd1; k_col = 2'd1; end
            4'd5: begin k_row = 2'd1; k_col = 2'd2; end
            4'd6: begin k_row = 2'd2; k_col = 2'd0; end
            4'd7: begin k_row = 2'd2; k_col = 2'd1; end
            4'd8: begin k_row = 2'd2; k_col = 2'd2; end
            default: begin k_row = 2'd0; k_col = 2'd0; end
        endcase
    end

    assign win_row  = row + {3'd0, k_row};
    assign win_col  = col + {3'd0, k_col};
    assign img_addr = (state == S_FETCH)
                      ? ({5'd0, win_row} * 10'd28 + {5'd0, win_col})
                      : 10'd0;

    // img_data always belongs to the tap fetched one cycle earlier, so the
    // weight index lags the fetch counter by one; DRAIN consumes tap 8.
    assign w_idx      = (state == S_DRAIN) ? 4'd8 : (k - 4'd1);
    assign w_cur      = weight(filt, w_idx);
    assign pix_ext    = {5'd0, img_data};
    assign w_ext      = {{9{w_cur[3]}}, w_cur};
    assign prod       = pix_ext * w_ext;
    assign acc_sum    = acc + prod;
    assign last_pixel = (row == 5'd25) && (col == 5'd25);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= S_IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:  if (start) state_next = S_FETCH;
            S_FETCH: if (k == 4'd8) state_next = S_DRAIN;
            S_DRAIN: state_next = S_OUT;
            S_OUT:   state_next = last_pixel ? S_DONE : S_FETCH;
            S_DONE:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // The result is registered on the DRAIN->OUT edge from the final sum,
    // so the strobe lands in the OUT cycle itself.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            row       <= 5'd0;
            col       <= 5'd0;
            k         <= 4'd0;
            filt      <= 2'd0;
            acc       <= 13'sd0;
            data_out  <= 8'd0;
            valid_out <= 1'b0;
            done      <= 1'b0;
        end else begin
            valid_out <= 1'b0;
            done      <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        filt <= filter_select;
                        row  <= 5'd0;
                        col  <= 5'd0;
                        k    <= 4'd0;
                    end
                end
                S_FETCH: begin
                    acc <= (k == 4'd0) ? 13'sd0 : acc_sum;
                    k   <= k + 4'd1;
                end
                S_DRAIN: begin
                    acc       <= acc_sum;
                    data_out  <= relu_sat(acc_sum);
                    valid_out <= 1'b1;
                end
                S_OUT: begin
                    k    <= 4'd0;
                    done <= last_pixel;
                    if (last_pixel) begin
                        row <= 5'd0;
                        col <= 5'd0;
                    end else if (col == 5'd25) begin
                        col <= 5'd0;
                        row <= row + 5'd1;
                    end else begin
                        col <= col + 5'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_conv_layer.sv
// Testbench for conv_layer: behavioural image RAM, reference convolution
// model feeding an expected-output queue, and one task per scenario.
module tb_conv_layer;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [1:0] filter_select;
    logic [9:0] img_addr;
    logic [7:0] img_data;
    logic [7:0] data_out;
    logic       valid_out;
    logic       done;

    int checks = 0;
    int errors = 0;

    logic [7:0] mem [0:783];
    logic [7:0] sb [$];
    logic [7:0] got [0:675];

    int kern [4][9] = '{'{-1,  0,  1, -2, 0,  2, -1,  0,  1},
                        '{-1, -2, -1,  0, 0,  0,  1,  2,  1},
                        '{ 0, -1,  0, -1, 4, -1,  0, -1,  0},
                        '{ 2,  1,  0,  1, 0, -1,  0, -1, -2}};

    always #5 clk = ~clk;

    conv_layer dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .filter_select (filter_select),
        .img_addr      (img_addr),
        .img_data      (img_data),
        .data_out      (data_out),
        .valid_out     (valid_out),
        .done          (done)
    );

    // Synchronous single-port image RAM, 1-cycle read latency.
    always @(posedge clk)
        img_data <= (img_addr < 10'd784) ? mem[img_addr] : 8'hxx;

    function automatic logic [7:0] model_px(input int f, input int r, input int c);
        int s;
        s = 0;
        for (int kr = 0; kr < 3; kr++)
            for (int kc = 0; kc < 3; kc++)
                s += kern[f][kr*3+kc] * int'(mem[(r+kr)*28 + c + kc]);
        if (s < 0) return 8'd0;
        if (s > 255) return 8'd255;
        return 8'(s);
    endfunction

    task automatic fill_uniform(input int v);
        for (int i = 0; i < 784; i++) mem[i] = 8'(v);
    endtask

    task automatic fill_step(input int left, input int right);
        for (int i = 0; i < 784; i++) mem[i] = ((i % 28) < 14) ? 8'(left) : 8'(right);
    endtask

    task automatic fill_single();
        for (int i = 0; i < 784; i++) mem[i] = 8'd0;
        mem[145] = 8'd10;
    endtask

    // One full run: queue the model's 676 outputs, start, then check every
    // strobe's value and cycle, the first pixel's address sequence, and done.
    task automatic run_one(input logic [1:0] f, input bit disturb, input string tag);
        int cyc;
        int n;
        int exp_addr;
        bit got_done;
        logic [7:0] exp;
        sb.delete();
        for (int r = 0; r < 26; r++)
            for (int c = 0; c < 26; c++)
                sb.push_back(model_px(int'(f), r, c));
        repeat (2) @(negedge clk);
        start = 1'b1;
        filter_select = f;
        @(posedge clk);
        #1;
        start = 1'b0;
        cyc = 1;
        n = 0;
        got_done = 1'b0;
        while (!got_done && cyc <= 7600) begin
            if (disturb && cyc == 3000) begin
                start = 1'b1;
                filter_select = ~f;
            end
            if (disturb && cyc == 3001) start = 1'b0;
            if (cyc <= 9) begin
                exp_addr = ((cyc - 1) / 3) * 28 + (cyc - 1) % 3;
                checks++;
                if (img_addr !== 10'(exp_addr)) begin
                    errors++;
                    $display("FAIL %s addr k=%0d got %0d want %0d", tag, cyc - 1, img_addr, exp_addr);
                end
            end
            if (valid_out === 1'b1) begin
                checks++;
                if (cyc != 11*n + 11) begin
                    errors++;
                    $display("FAIL %s strobe_time pix%0d got cycle %0d want %0d", tag, n, cyc, 11*n + 11);
                end
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL %s extra_strobe got %0d want none", tag, n + 1);
                end else begin
                    exp = sb.pop_front();
                    if (data_out !== exp) begin
                        errors++;
                        $display("FAIL %s data pix%0d got %0d want %0d", tag, n, data_out, exp);
                    end
                end
                if (n < 676) got[n] = data_out;
                n++;
            end
            if (done === 1'b1) begin
                got_done = 1'b1;
                checks++;
                if (cyc != 7437) begin
                    errors++;
                    $display("FAIL %s done_time got %0d want 7437", tag, cyc);
                end
                checks++;
                if (n != 676) begin
                    errors++;
                    $display("FAIL %s strobe_count got %0d want 676", tag, n);
                end
            end
            if (!got_done) begin
                @(posedge clk);
                #1;
                cyc++;
            end
        end
        if (!got_done) begin
            checks++;
            errors++;
            $display("FAIL %s done_timeout got no done want done by 7437", tag);
        end else begin
            @(posedge clk);
            #1;
            checks++;
            if (done !== 1'b0 || valid_out !== 1'b0) begin
                errors++;
                $display("FAIL %s done_single got done=%0b valid=%0b want 0 0", tag, done, valid_out);
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        start = 1'b0;
        filter_select = 2'd0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (data_out !== 8'd0 || valid_out !== 1'b0 || done !== 1'b0 || img_addr !== 10'd0) begin
            errors++;
            $display("FAIL reset got d=%0d v=%0b done=%0b a=%0d want all 0",
                     data_out, valid_out, done, img_addr);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_zero_image();
        fill_uniform(0);
        run_one(2'd0, 1'b0, "zero");
    endtask

    task automatic test_back_to_back_uniform();
        fill_uniform(100);
        for (int f = 0; f < 4; f++) run_one(2'(f), 1'b0, "uniform");
    endtask

    task automatic test_step();
        fill_step(0, 200);
        run_one(2'd0, 1'b0, "step");
        for (int r = 0; r < 26; r += 5) begin
            checks++;
            if (got[r*26+12] !== 8'd255 || got[r*26+13] !== 8'd255) begin
                errors++;
                $display("FAIL step_edge row%0d got %0d %0d want 255 255", r, got[r*26+12], got[r*26+13]);
            end
            checks++;
            if (got[r*26+11] !== 8'd0 || got[r*26+14] !== 8'd0) begin
                errors++;
                $display("FAIL step_flat row%0d got %0d %0d want 0 0", r, got[r*26+11], got[r*26+14]);
            end
        end
        fill_step(200, 0);
        run_one(2'd0, 1'b0, "step_inv");
        checks++;
        if (got[12] !== 8'd0 || got[13] !== 8'd0) begin
            errors++;
            $display("FAIL step_inv_edge got %0d %0d want 0 0", got[12], got[13]);
        end
    endtask

    task automatic test_mid_run_disturb();
        fill_step(0, 200);
        run_one(2'd0, 1'b1, "disturb");
    endtask

    // Abort a run with reset, then restart with the single-pixel image; the
    // restart's address/timing checks confirm it begins again at (0,0).
    task automatic test_async_abort_and_single();
        fill_step(0, 200);
        repeat (2) @(negedge clk);
        start = 1'b1;
        filter_select = 2'd0;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (149) @(posedge clk);
        #1;
        checks++;
        if (data_out !== 8'd255) begin
            errors++;
            $display("FAIL abort_pre got %0d want 255", data_out);
        end
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (data_out !== 8'd0 || valid_out !== 1'b0 || done !== 1'b0 || img_addr !== 10'd0) begin
            errors++;
            $display("FAIL abort_now got d=%0d v=%0b done=%0b a=%0d want all 0",
                     data_out, valid_out, done, img_addr);
        end
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            checks++;
            if (done !== 1'b0 || valid_out !== 1'b0) begin
                errors++;
                $display("FAIL abort_hold got done=%0b v=%0b want 0 0", done, valid_out);
            end
        end
        @(negedge clk);
        rst = 1'b0;
        fill_single();
        run_one(2'd2, 1'b0, "single");
        checks++;
        if (got[4*26+4] !== 8'd40) begin
            errors++;
            $display("FAIL single_center got %0d want 40", got[4*26+4]);
        end
        checks++;
        if (got[3*26+4] !== 8'd0 || got[5*26+4] !== 8'd0 ||
            got[4*26+3] !== 8'd0 || got[4*26+5] !== 8'd0) begin
            errors++;
            $display("FAIL single_neighbours got %0d %0d %0d %0d want 0",
                     got[3*26+4], got[5*26+4], got[4*26+3], got[4*26+5]);
        end
    endtask

    initial begin
        test_reset();
        test_zero_image();
        test_back_to_back_uniform();
        test_step();
        test_mid_run_disturb();
        test_async_abort_and_single();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
